// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: 4x4 hex matrix keypad scanner with debounce, a 32-bit
// shift-in entry register, and a committed value register offered to the
// processor under a valid/ack handshake.
//
// Optional build feature: define KEYPAD_LONGPRESS_CLEAR_EN to make a key held
// for LONGPRESS_SCANS samples zero the entry register (once per press).
//
// Handshake: value_valid stays high while value_out holds a value the
// consumer has not yet taken; value_ack in a cycle with value_valid high
// consumes it. A commit is taken only when value_out is free (value_valid low)
// or is being consumed in the same cycle (value_ack high); otherwise the
// commit is dropped and the sticky overrun flag is raised.
module hex_keypad_entry #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_SCANS  = 4,
   parameter int LONGPRESS_SCANS = 400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   input  logic        clear,
   input  logic        commit,
   input  logic        value_ack,
   output logic [31:0] entry_out,
   output logic [3:0]  digit_count,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [31:0] value_out,
   output logic        value_valid,
   output logic        overrun
);

   localparam int             CW        = $clog2(SCAN_DIV);
   localparam logic [CW-1:0]  SLOT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [15:0]    DEB_N     = 16'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

   // state is the FSM's observable state for checkers bound to this module
   state_t        state;
   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic [CW-1:0] slot_cnt;
   logic [1:0]    col_idx;
   logic [3:0]    pattern;
   logic [15:0]   stable_cnt;
   logic [15:0]   release_cnt;

   logic          sample;
   logic          rows_idle;
   logic          accept;
   logic [3:0]    accept_code;
   logic          lp_fire;
   logic          commit_ok;
   logic [31:0]   next_entry;
   logic [3:0]    next_count;

   // Lowest-numbered active (low) row wins when several rows are pressed
   function automatic logic [1:0] low_row(input logic [3:0] r);
      if (!r[0])      return 2'd0;
      else if (!r[1]) return 2'd1;
      else if (!r[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   assign sample    = (slot_cnt == SLOT_LAST);
   assign rows_idle = &row_sync;
   assign commit_ok = commit && (!value_valid || value_ack);

   // Two-flop synchronizer for the asynchronous, pulled-up row lines
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

   // Column slot timer; the last cycle of each slot is the sample point
   always_ff @(posedge clk) begin
      if (rst)         slot_cnt <= '0;
      else if (sample) slot_cnt <= '0;
      else             slot_cnt <= slot_cnt + 1'b1;
   end

   // Decide whether this sample completes a debounced press
   always_comb begin
      accept      = 1'b0;
      accept_code = {low_row(pattern), col_idx};
      if (sample) begin
         case (state)
            S_SCAN: begin
               if (!rows_idle && DEBOUNCE_SCANS == 1) begin
                  accept      = 1'b1;
                  accept_code = {low_row(row_sync), col_idx};
               end
            end
            S_DEBOUNCE: begin
               if (row_sync == pattern && (stable_cnt + 16'd1) == DEB_N)
                  accept = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Scan / debounce / held FSM, advancing the column only when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_SCAN;
         col_out     <= 4'b1110;
         col_idx     <= 2'd0;
         pattern     <= 4'hF;
         stable_cnt  <= '0;
         release_cnt <= '0;
      end else if (sample) begin
         case (state)
            S_SCAN: begin
               if (rows_idle) begin
                  col_out <= {col_out[2:0], col_out[3]};
                  col_idx <= col_idx + 2'd1;
               end else begin
                  pattern     <= row_sync;
                  stable_cnt  <= 16'd1;
                  release_cnt <= '0;
                  state       <= accept ? S_HELD : S_DEBOUNCE;
               end
            end
            S_DEBOUNCE: begin
               if (row_sync == pattern) begin
                  stable_cnt <= stable_cnt + 16'd1;
                  if (accept) begin
                     state       <= S_HELD;
                     release_cnt <= '0;
                  end
               end else begin
                  state   <= S_SCAN;
                  col_out <= {col_out[2:0], col_out[3]};
                  col_idx <= col_idx + 2'd1;
               end
            end
            S_HELD: begin
               if (rows_idle) begin
                  if ((release_cnt + 16'd1) == DEB_N) begin
                     state       <= S_SCAN;
                     release_cnt <= '0;
                     col_out     <= {col_out[2:0], col_out[3]};
                     col_idx     <= col_idx + 2'd1;
                  end else begin
                     release_cnt <= release_cnt + 16'd1;
                  end
               end else begin
                  release_cnt <= '0;
               end
            end
            default: state <= S_SCAN;
         endcase
      end
   end

`ifdef KEYPAD_LONGPRESS_CLEAR_EN
   localparam logic [15:0] LP_N = 16'(LONGPRESS_SCANS);
   logic [15:0] lp_cnt;
   logic        lp_done;

   assign lp_fire = sample && (state == S_HELD) && !rows_idle && !lp_done &&
                    ((lp_cnt + 16'd1) == LP_N);

   // Count consecutive held samples; fire the clear once per press
   always_ff @(posedge clk) begin
      if (rst || state != S_HELD) begin
         lp_cnt  <= '0;
         lp_done <= 1'b0;
      end else if (sample) begin
         if (rows_idle) begin
            lp_cnt <= '0;
         end else begin
            if (!lp_done) lp_cnt <= lp_cnt + 16'd1;
            if (lp_fire)  lp_done <= 1'b1;
         end
      end
   end
`else
   assign lp_fire = 1'b0;
`endif

   // Entry value after this cycle's key and clear, before any commit
   always_comb begin
      next_entry = entry_out;
      next_count = digit_count;
      if (accept) begin
         next_entry = {entry_out[27:0], accept_code};
         next_count = (digit_count == 4'd8) ? 4'd8 : digit_count + 4'd1;
      end
      if (clear || lp_fire) begin
         next_entry = '0;
         next_count = '0;
      end
   end

   // Entry register, key report, and committed-value handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         entry_out   <= '0;
         digit_count <= '0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         value_out   <= '0;
         value_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         key_valid <= accept;
         if (accept) key_code <= accept_code;
         if (commit_ok) begin
            value_out   <= next_entry;
            value_valid <= 1'b1;
            entry_out   <= '0;
            digit_count <= '0;
         end else begin
            entry_out   <= next_entry;
            digit_count <= next_count;
            if (value_ack) value_valid <= 1'b0;
            if (commit)    overrun     <= 1'b1;
         end
      end
   end

endmodule

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
- Scans a 4x4 hex matrix keypad and debounces key presses.
- Shifts each accepted hex digit into a 32-bit entry register, giving the input-side counterpart of the 8-digit hex display path.
- A commit strobe latches the entry into a value register presented to the processor with a valid/ack handshake.
- Sits between board keypad pins (PMOD) and the processor's memory-mapped input port.

Parameters:
- SCAN_DIV, 50000: clk cycles per column slot. Rows are sampled on the last cycle of each slot. Minimum 2.
- DEBOUNCE_SCANS, 4: consecutive matching samples required to accept a press or a release. Minimum 1.
- LONGPRESS_SCANS, 400: held-key samples before a long-press clear (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- row_in  in  4  keypad rows, active-low, asynchronous, externally pulled up
- col_out  out  4  keypad column drive, active-low, exactly one bit low
- clear  in  1  synchronous pulse: zero the entry register and digit_count
- commit  in  1  synchronous pulse: latch the entry into value_out
- value_ack  in  1  consumer has taken value_out
- entry_out  out  32  live entry register, feeds the display
- digit_count  out  4  digits entered since last clear/commit, saturates at 8
- key_valid  out  1  one-cycle pulse per accepted key
- key_code  out  4  code of last accepted key
- value_out  out  32  committed value
- value_valid  out  1  value_out holds an un-acked value
- overrun  out  1  sticky: a commit was dropped

Behaviour:
- Reset rst is synchronous and active-high; the clock is clk.
- Reset values:
  - col_out = 4'b1110, all other outputs 0.
  - Internal counters 0, FSM in SCAN, row synchronizer set to 4'hF.
- row_in passes through a 2-flop synchronizer. "Sample" means the synchronized rows on the cycle where the slot counter equals SCAN_DIV-1; the counter then wraps to 0.
- Key code = {row_idx[1:0], col_idx[1:0]}. If several rows are low, the lowest row index wins.
- FSM SCAN:
  - At a sample with all rows high: advance the column 0→1→2→3→0 by rotating col_out.
  - Otherwise: capture the row pattern, hold the column, set stable count to 1, go to DEBOUNCE. If DEBOUNCE_SCANS==1, accept immediately.
- FSM DEBOUNCE:
  - At a sample equal to the captured pattern: increment stable count.
  - On reaching DEBOUNCE_SCANS, accept the key and go to HELD.
  - Mismatch (including release): go to SCAN and advance the column. No key is emitted.
- Accept, on the cycle after the accepting sample:
  - key_valid=1 for 1 cycle and key_code updated.
  - entry_out <= {entry_out[27:0], code}; older digits fall off the top.
  - digit_count increments, saturating at 8.
- FSM HELD: column held.
  - A sample with all rows high increments the release count; any low row resets it to 0.
  - At DEBOUNCE_SCANS: go to SCAN and advance the column. No auto-repeat.
- clear: zeroes entry_out and digit_count next cycle. If it coincides with an accept, the clear wins and the key is still reported on key_valid/key_code.
- commit:
  - Accepted when value_valid==0 or value_ack==1 in the same cycle. Next cycle: value_out <= entry_out, value_valid=1, and entry_out and digit_count are zeroed.
  - Otherwise it is dropped: overrun=1, sticky until rst; entry_out is unchanged.
  - commit together with an accept: the shifted value (including the new digit) is committed.
  - commit together with clear: 0 is committed.
- value_ack with value_valid=1 and no accepted commit: value_valid <= 0. value_ack while value_valid=0 is ignored.
- All state is synchronous; a reset mid-debounce or mid-hold discards the press.

Optional Feature:
- Macro: KEYPAD_LONGPRESS_CLEAR_EN
- Defined:
  - In HELD, count consecutive samples with the key still down.
  - On reaching LONGPRESS_SCANS, zero entry_out and digit_count once per press; key_valid does not pulse.
  - The counter resets on leaving HELD.
- Undefined: no long-press logic, and LONGPRESS_SCANS is unused.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, LONGPRESS_SCANS=10):
- Reset, no keys → col_out cycles 1110,1101,1011,0111 every 4 clk; all outputs 0.
- Hold row 2 low while column 1 is driven, for ≥6 samples, then release → exactly one key_valid, key_code=4'h9, entry_out=32'h9, digit_count=1; scan resumes after 3 high samples.
- Row low for only 2 samples (bounce) → no key_valid; scan resumes at the next column.
- Enter keys 1..9 in order → entry_out=32'h23456789, digit_count=8. Then commit → value_out=32'h23456789, value_valid=1, entry_out=0.
- With value_valid=1, commit without ack → overrun=1, value_out unchanged. Commit with ack in the same cycle → new value latched, value_valid stays 1.
- With KEYPAD_LONGPRESS_CLEAR_EN, entry=32'h12, hold key 3 for 15 samples → one key_valid (entry 32'h123), then entry_out=0 at the long-press point. Without the macro → entry stays 32'h123.
